// File: rtl/smm_result_sorter.sv
// Re-orders the (row,col,val) result stream of the sparse matrix multiplier into row-major order.
// Entries are kept sorted in a register array by one insertion per cycle; duplicates merge saturating.
module smm_result_sorter #(
    parameter int unsigned DEPTH = 48,
    parameter int unsigned IDX_W = 5,
    parameter int unsigned VAL_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_row,
    input  logic [IDX_W-1:0] in_col,
    input  logic [VAL_W-1:0] in_val,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_last,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col,
    output logic [VAL_W-1:0] out_val,
    output logic             overflow
);

    localparam int unsigned KEY_W = 2 * IDX_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q [DEPTH];
    logic [KEY_W-1:0] key_d [DEPTH];
    logic [VAL_W-1:0] val_q [DEPTH];
    logic [VAL_W-1:0] val_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             overflow_q, overflow_d;

    logic             take;
    logic             drain_last;
    logic [KEY_W-1:0] in_key;
    logic [KEY_W-1:0] drain_key;
    logic [DEPTH-1:0] lt;
    logic [DEPTH-1:0] eq;

    function automatic logic [VAL_W-1:0] sat_add(input logic [VAL_W-1:0] a,
                                                 input logic [VAL_W-1:0] b);
        logic [VAL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[VAL_W] ? {VAL_W{1'b1}} : s[VAL_W-1:0];
    endfunction

    assign in_key     = {in_row, in_col};
    assign take       = in_valid && in_ready;
    assign drain_last = (idx_q == count_q - CNT_W'(1));
    assign drain_key  = key_q[idx_q];
    assign overflow   = overflow_q;

    // Only occupied slots take part in the key comparison.
    always_comb begin
        lt = '0;
        eq = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lt[i] = (CNT_W'(i) < count_q) && (key_q[i] < in_key);
            eq[i] = (CNT_W'(i) < count_q) && (key_q[i] == in_key);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StLoad;
            StLoad:  if (!in_valid) state_d = StDrain;
            StDrain: if (drain_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q != StDrain);
    end

    // Array insert / merge and drain bookkeeping
    always_comb begin
        key_d      = key_q;
        val_d      = val_q;
        count_d    = count_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        if (state_q == StIdle && in_valid) begin
            overflow_d = 1'b0;
        end
        if (take) begin
            if (|eq) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (eq[i]) val_d[i] = sat_add(val_q[i], in_val);
                end
            end else if (count_q < CNT_W'(DEPTH)) begin
                // Slot j takes the new entry where the "less than" run ends.
                if (!lt[0]) begin
                    key_d[0] = in_key;
                    val_d[0] = in_val;
                end
                for (int j = 1; j < DEPTH; j++) begin
                    if (!lt[j]) begin
                        if (lt[j-1]) begin
                            key_d[j] = in_key;
                            val_d[j] = in_val;
                        end else begin
                            key_d[j] = key_q[j-1];
                            val_d[j] = val_q[j-1];
                        end
                    end
                end
                count_d = count_q + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (state_q == StDrain) begin
            if (drain_last) begin
                idx_d   = '0;
                count_d = '0;
            end else begin
                idx_d = idx_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            key_q      <= key_d;
            val_q      <= val_d;
        end
    end

    // Registered output stream; all fields forced to zero outside DRAIN.
    always_ff @(posedge clk) begin
        if (rst || state_q != StDrain) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_val   <= '0;
        end else begin
            out_valid <= 1'b1;
            out_last  <= drain_last;
            out_row   <= drain_key[KEY_W-1:IDX_W];
            out_col   <= drain_key[IDX_W-1:0];
            out_val   <= val_q[idx_q];
        end
    end

endmodule

// File: tb/tb_smm_result_sorter.sv
// Bench for smm_result_sorter: table-driven frames plus hand-written multi-cycle sequences,
// with a scoreboard queue of expected sorted triplets.
module tb_smm_result_sorter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [4:0] in_row, in_col;
    logic [8:0] in_val;
    logic       in_ready, out_valid, out_last, overflow;
    logic [4:0] out_row, out_col;
    logic [8:0] out_val;

    smm_result_sorter #(.DEPTH(48), .IDX_W(5), .VAL_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_row    (in_row),
        .in_col    (in_col),
        .in_val    (in_val),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_val   (out_val),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] row;
        logic [4:0] col;
        logic [8:0] val;
        logic       last;
    } out_t;

    typedef struct {
        logic [4:0] row, col;
        logic [8:0] val;
        logic       exp_v;
        out_t       exp;
        logic       eof;
        logic       exp_ovf;
    } vec_t;

    out_t sb[$];
    out_t mon_e;
    vec_t tbl[12];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lasts = 0;
    logic [8:0] model_val[48];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [4:0] r, input logic [4:0] c, input logic [8:0] v);
        in_valid = 1'b1;
        in_row   = r;
        in_col   = c;
        in_val   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_row   = '0;
        in_col   = '0;
        in_val   = '0;
    endtask

    // Waits (bounded) for the out_last beat, then checks the stream has stopped.
    task automatic wait_last(input int start);
        for (int t = 0; t < 200 && lasts == start; t++) @(posedge clk);
        #1;
        check("drain_finished", 32'(lasts != start), 32'd1);
        check("valid_after_last", 32'(out_valid), 32'd0);
    endtask

    task automatic close_frame();
        int start;
        start = lasts;
        idle_inputs();
        @(posedge clk);
        #1;
        check("latency_e0_no_valid", 32'(out_valid), 32'd0);
        check("ready_in_drain", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("latency_e1_valid", 32'(out_valid), 32'd1);
        wait_last(start);
    endtask

    initial begin
        // row, col, val, exp_v, expected {row,col,val,last}, eof, expected overflow
        tbl[0]  = '{5'd2,  5'd3,  9'd5,   1'b1, '{5'd0,  5'd1,  9'd7,   1'b0}, 1'b0, 1'b0};
        tbl[1]  = '{5'd0,  5'd1,  9'd7,   1'b1, '{5'd2,  5'd0,  9'd4,   1'b0}, 1'b0, 1'b0};
        tbl[2]  = '{5'd2,  5'd0,  9'd4,   1'b1, '{5'd2,  5'd3,  9'd5,   1'b1}, 1'b1, 1'b0};
        tbl[3]  = '{5'd1,  5'd1,  9'd300, 1'b1, '{5'd1,  5'd1,  9'd511, 1'b1}, 1'b0, 1'b0};
        tbl[4]  = '{5'd1,  5'd1,  9'd300, 1'b0, '{5'd0,  5'd0,  9'd0,   1'b0}, 1'b1, 1'b0};
        tbl[5]  = '{5'd31, 5'd31, 9'd1,   1'b1, '{5'd31, 5'd31, 9'd1,   1'b1}, 1'b1, 1'b0};
        tbl[6]  = '{5'd3,  5'd4,  9'd10,  1'b1, '{5'd0,  5'd31, 9'd1,   1'b0}, 1'b0, 1'b0};
        tbl[7]  = '{5'd3,  5'd4,  9'd20,  1'b1, '{5'd3,  5'd3,  9'd511, 1'b0}, 1'b0, 1'b0};
        tbl[8]  = '{5'd0,  5'd31, 9'd1,   1'b1, '{5'd3,  5'd4,  9'd30,  1'b0}, 1'b0, 1'b0};
        tbl[9]  = '{5'd31, 5'd0,  9'd2,   1'b1, '{5'd31, 5'd0,  9'd2,   1'b1}, 1'b0, 1'b0};
        tbl[10] = '{5'd3,  5'd3,  9'd500, 1'b0, '{5'd0,  5'd0,  9'd0,   1'b0}, 1'b0, 1'b0};
        tbl[11] = '{5'd3,  5'd3,  9'd100, 1'b0, '{5'd0,  5'd0,  9'd0,   1'b0}, 1'b1, 1'b0};

        rst = 1'b1;
        idle_inputs();

        fork
            forever begin
                @(negedge clk);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got (%0d,%0d,%0d), expected no output",
                                 out_row, out_col, out_val);
                    end else begin
                        mon_e = sb.pop_front();
                        check("sorted_out", {12'b0, out_row, out_col, out_val, out_last},
                              {12'b0, mon_e});
                    end
                    if (out_last) lasts++;
                end else begin
                    check("idle_zero", {12'b0, out_last, out_row, out_col, out_val}, 32'd0);
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table frames: sorting, saturating merge, single entry
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].exp_v) sb.push_back(tbl[i].exp);
            put(tbl[i].row, tbl[i].col, tbl[i].val);
            if (tbl[i].eof) begin
                close_frame();
                check("frame_overflow", 32'(overflow), 32'(tbl[i].exp_ovf));
                check("frame_sb_empty", 32'(sb.size()), 32'd0);
            end
        end

        // 50 distinct keys into 48 slots, then a merge into a held key while full
        for (int k = 0; k < 50; k++) begin
            put(5'(k >> 5), 5'(k & 31), 9'(k + 1));
            if (k < 48) model_val[k] = 9'(k + 1);
        end
        put(5'd0, 5'd5, 9'd510);
        model_val[5] = 9'd511;
        for (int k = 0; k < 48; k++) sb.push_back('{5'(k >> 5), 5'(k & 31), model_val[k], k == 47});
        close_frame();
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_sb_empty", 32'(sb.size()), 32'd0);

        // in_valid pulsed during DRAIN is ignored
        begin
            int start;
            put(5'd4, 5'd4, 9'd1);
            put(5'd2, 5'd2, 9'd2);
            put(5'd6, 5'd6, 9'd3);
            put(5'd1, 5'd1, 9'd4);
            sb.push_back('{5'd1, 5'd1, 9'd4, 1'b0});
            sb.push_back('{5'd2, 5'd2, 9'd2, 1'b0});
            sb.push_back('{5'd4, 5'd4, 9'd1, 1'b0});
            sb.push_back('{5'd6, 5'd6, 9'd3, 1'b1});
            start = lasts;
            idle_inputs();
            @(posedge clk);
            #1;
            check("drain_ready_e0", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            in_row   = 5'd0;
            in_col   = 5'd0;
            in_val   = 9'd99;
            @(posedge clk);
            #1;
            check("drain_ready_e1", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            check("drain_ready_e2", 32'(in_ready), 32'd0);
            idle_inputs();
            wait_last(start);
            check("overflow_cleared", 32'(overflow), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check("no_spurious_frame", 32'(out_valid), 32'd0);
            check("ready_after_drain", 32'(in_ready), 32'd1);
            check("pulse_sb_empty", 32'(sb.size()), 32'd0);
        end

        // Reset mid-DRAIN after two outputs, then a fresh frame
        put(5'd5, 5'd5, 9'd1);
        put(5'd4, 5'd4, 9'd2);
        put(5'd3, 5'd3, 9'd3);
        put(5'd2, 5'd2, 9'd4);
        sb.push_back('{5'd2, 5'd2, 9'd4, 1'b0});
        sb.push_back('{5'd3, 5'd3, 9'd3, 1'b0});
        idle_inputs();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_zero", {12'b0, out_last, out_row, out_col, out_val}, 32'd0);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", 32'(in_ready), 32'd1);
        sb.push_back('{5'd0, 5'd0, 9'd1, 1'b1});
        put(5'd0, 5'd0, 9'd1);
        close_frame();
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);
        check("post_rst_overflow", 32'(overflow), 32'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
